// File: rtl/aes128_dsp_inv_pkg.sv
// aes128_dsp_inv_pkg: AES tables and GF(2^8) helpers shared by the AES-128 cipher cores
package aes128_dsp_inv_pkg;
  typedef enum logic [1:0] {IDLE, KEXP, ROUND, FIN} state_t;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d};
  localparam logic [79:0] RCON = 80'h01020408102040801b36;
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return RCON[79 - 8*int'(i) -: 8];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul_9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction
  function automatic logic [7:0] mul_b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction
  function automatic logic [7:0] mul_d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction
  function automatic logic [7:0] mul_e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round, InvMixColumns bypassed on the last round
module aes_inv_round import aes128_dsp_inv_pkg::*; (
  input  logic [127:0] din,
  input  logic [127:0] rkey,
  input  logic         last,
  output logic [127:0] dout
);
  logic [0:15][7:0] i_b, k_b, s_b, m_b;
  assign i_b = din;
  assign k_b = rkey;
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign s_b[i] = inv_sbox(i_b[4*(((i/4) - (i%4) + 4) % 4) + i%4]) ^ k_b[i];
    assign m_b[i] = mul_e(s_b[i]) ^ mul_b(s_b[4*(i/4) + (i+1)%4])
                  ^ mul_d(s_b[4*(i/4) + (i+2)%4]) ^ mul_9(s_b[4*(i/4) + (i+3)%4]);
  end
  assign dout = last ? s_b : m_b;
endmodule

// File: rtl/aes128_dsp_inv.sv
// aes128_dsp_inv: iterative AES-128 decryptor, key run forward to K10 then unwound one round per cycle
module aes128_dsp_inv import aes128_dsp_inv_pkg::*; (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [127:0] DIN,
  input  logic [127:0] KEY,
  output logic         BUSY,
  output logic         DONE,
  output logic [127:0] DOUT
);
  state_t st;
  logic [3:0] cnt;
  logic [127:0] s, k, k_fwd, k_bwd, r_out;
  logic [31:0] rcw, f0, f1, f2, f3, b0, b1, b2, b3;
  logic accept;
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  assign rcw = {rcon(cnt), 24'h0};
  assign f0 = k[127:96] ^ sub_rot(k[31:0]) ^ rcw;
  assign f1 = k[95:64] ^ f0;
  assign f2 = k[63:32] ^ f1;
  assign f3 = k[31:0] ^ f2;
  assign k_fwd = {f0, f1, f2, f3};
  // backward step rebuilds the previous last word first, since it feeds the S-box
  assign b3 = k[31:0] ^ k[63:32];
  assign b2 = k[63:32] ^ k[95:64];
  assign b1 = k[95:64] ^ k[127:96];
  assign b0 = k[127:96] ^ sub_rot(b3) ^ rcw;
  assign k_bwd = {b0, b1, b2, b3};
  assign accept = START && (st == IDLE || st == FIN);
  aes_inv_round u_round (.din(s), .rkey(k_bwd), .last(cnt == 4'd0), .dout(r_out));
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st <= IDLE;
      cnt <= '0;
      s <= '0;
      k <= '0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      DOUT <= '0;
    end else begin
      DONE <= st == FIN;
      if (st == FIN) DOUT <= s;
      case (st)
        KEXP: begin
          k <= k_fwd;
          cnt <= cnt == 4'd9 ? cnt : cnt + 4'd1;
          if (cnt == 4'd9) begin
            s <= s ^ k_fwd;
            st <= ROUND;
          end
        end
        ROUND: begin
          s <= r_out;
          k <= k_bwd;
          cnt <= cnt == 4'd0 ? cnt : cnt - 4'd1;
          if (cnt == 4'd0) begin
            st <= FIN;
            BUSY <= 1'b0;
          end
        end
        default: begin
          st <= accept ? KEXP : IDLE;
          if (accept) begin
            s <= DIN;
            k <= KEY;
            cnt <= '0;
            BUSY <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes128_dsp_inv.sv
// tb_aes128_dsp_inv: vector table, corner sequences and random round trips against an AES model
module tb_aes128_dsp_inv;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [127:0] din = '0, key = '0;
  logic busy, done;
  logic [127:0] dout;
  int n_chk = 0, n_fail = 0;
  logic [7:0] sb[256], isb[256];
  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_C = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_P = 128'h3243f6a8885a308d313198a2e0370734;
  typedef struct {logic [127:0] key, din, exp;} vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  aes128_dsp_inv dut (.CLK(clk), .RST(rst_n), .START(start), .DIN(din), .KEY(key),
                      .BUSY(busy), .DONE(done), .DOUT(dout));

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] y = 8'h01;
      if (x == 0) y = 8'h00;
      else for (int e = 0; e < 254; e++) y = gm(y, 8'(x));
      sb[x] = y ^ rl(y, 1) ^ rl(y, 2) ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    logic [1407:0] ks;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] x, input logic [31:0] co);
    logic [0:15][7:0] s = x, o;
    logic [0:3][7:0] c = co;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++) begin
        o[4*col+row] = 8'h00;
        for (int j = 0; j < 4; j++) o[4*col+row] ^= gm(c[(j-row+4)%4], s[4*col+j]);
      end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
    logic [1407:0] ks = expand(k);
    logic [0:15][7:0] s, t;
    s = p ^ ks[1407 -: 128];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++) t[4*col+row] = s[4*((col+row)%4)+row];
      s = (r < 10) ? mix(t, 32'h02030101) : t;
      s = s ^ ks[1407-128*r -: 128];
    end
    return s;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] c, input logic [127:0] k);
    logic [1407:0] ks = expand(k);
    logic [0:15][7:0] s, t;
    s = c ^ ks[127:0];
    for (int r = 9; r >= 0; r--) begin
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++) t[4*((col+row)%4)+row] = s[4*col+row];
      for (int i = 0; i < 16; i++) t[i] = isb[t[i]];
      s = t ^ ks[1407-128*r -: 128];
      if (r > 0) s = mix(s, 32'h0e0b0d09);
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // one operation; i1/i2 are edges (after acceptance) at which a stray START is driven
  task automatic run_op(input logic [127:0] k, input logic [127:0] c, input int i1, input int i2,
                        output int lat, output logic [127:0] out,
                        output logic b1, output logic b19, output logic b20);
    @(negedge clk);
    key = k;
    din = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    b1 = busy;
    b19 = 1'bx;
    b20 = 1'bx;
    lat = -1;
    out = 'x;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      din = rnd128();
      key = rnd128();
      start = (i == i1 || i == i2);
      @(posedge clk);
      #1;
      if (i == 19) b19 = busy;
      if (i == 20) b20 = busy;
      if (done) begin
        lat = i;
        out = dout;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, cnt_done, sel;
    logic [127:0] out, pend, p, k;
    logic b1, b19, b20;
    build_sbox();
    tbl[0] = '{C1_K, C1_C, C1_P};
    tbl[1] = '{B_K, B_C, B_P};
    for (int i = 2; i < 6; i++) begin
      k = rnd128();
      p = rnd128();
      tbl[i] = '{k, aes_enc(p, k), p};
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_dout", dout, 128'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].key, tbl[i].din, 0, 0, lat, out, b1, b19, b20);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(21));
      chk($sformatf("vec%0d_dout", i), out, tbl[i].exp);
      if (i == 0) begin
        chk("busy_after_accept", 128'(b1), 128'(1));
        chk("busy_before_fin", 128'(b19), 128'(1));
        chk("busy_in_fin", 128'(b20), 128'(0));
        chk("busy_in_done", 128'(busy), 128'(0));
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_done_pulse", i), 128'(done), 128'(0));
      chk($sformatf("vec%0d_dout_hold", i), dout, tbl[i].exp);
    end
    chk("model_c1", aes_dec(C1_C, C1_K), C1_P);

    run_op(C1_K, C1_C, 5, 12, lat, out, b1, b19, b20);
    chk("ignore_start_latency", 128'(lat), 128'(21));
    chk("ignore_start_dout", out, C1_P);
    cnt_done = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      cnt_done += int'(done);
    end
    chk("ignore_start_no_extra_done", 128'(cnt_done), 128'(0));
    chk("ignore_start_dout_hold", dout, C1_P);

    @(negedge clk);
    key = C1_K;
    din = C1_C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_busy_before", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    chk("midrst_dout", dout, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      cnt_done += int'(done);
    end
    chk("midrst_no_done", 128'(cnt_done), 128'(0));
    run_op(C1_K, C1_C, 0, 0, lat, out, b1, b19, b20);
    chk("after_rst_latency", 128'(lat), 128'(21));
    chk("after_rst_dout", out, C1_P);

    @(negedge clk);
    key = C1_K;
    din = C1_C;
    start = 1'b1;
    sel = 0;
    pend = C1_P;
    @(posedge clk);
    #1;
    for (int n = 0; n < 6; n++) begin
      lat = -1;
      for (int i = 1; i <= 25 && lat < 0; i++) begin
        @(posedge clk);
        #1;
        if (done) begin
          lat = i;
          out = dout;
        end
      end
      chk($sformatf("stream%0d_period", n), 128'(lat), 128'(21));
      chk($sformatf("stream%0d_dout", n), out, pend);
      pend = sel ? B_P : C1_P;
      sel ^= 1;
      key = sel ? B_K : C1_K;
      din = sel ? B_C : C1_C;
    end
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 25 && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        out = dout;
      end
    end
    chk("stream_drain_latency", 128'(lat), 128'(21));
    chk("stream_drain_dout", out, pend);

    for (int n = 0; n < 1000; n++) begin
      k = rnd128();
      p = rnd128();
      run_op(k, aes_enc(p, k), 0, 0, lat, out, b1, b19, b20);
      chk($sformatf("roundtrip%0d", n), out, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes128_dsp_inv.md
AES128_DSP_INV -- requirements
Module: aes128_dsp_inv

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 Port: CLK    input   1    rising-edge clock.
REQ-003 Port: RST    input   1    asynchronous, active-low reset.
REQ-004 Port: START  input   1    request to decrypt; sampled only when BUSY=0.
REQ-005 Port: DIN    input   128  ciphertext, bit 127 = byte 0, FIPS-197 byte order.
REQ-006 Port: KEY    input   128  cipher key (encryption key, not pre-expanded), same byte order.
REQ-007 Port: BUSY   output  1    high from the edge after START acceptance until the DONE cycle, exclusive.
REQ-008 Port: DONE   output  1    one-cycle pulse; DOUT is valid in that cycle.
REQ-009 Port: DOUT   output  128  plaintext; holds its value until the next accepted START.

Function
REQ-010 SHALL perform AES-128 inverse cipher (FIPS-197 sec. 5.3), one round per cycle, key schedule computed on the fly.
REQ-011 SHALL latch DIN and KEY on the edge where START=1 and BUSY=0; later DIN/KEY changes are ignored until DONE.
REQ-012 FSM states: IDLE, KEXP, ROUND, FIN; reset state IDLE.
REQ-013 IDLE -> KEXP on accepted START; 4-bit counter loaded to 0.
REQ-014 KEXP: 10 cycles; each cycle advances key register forward one round (Rcon 01,02,04,08,10,20,40,80,1B,36); on the 10th cycle state <= state XOR K10 and FSM -> ROUND, counter = 9.
REQ-015 ROUND: each cycle applies InvShiftRows, InvSubBytes, AddRoundKey(K_r), InvMixColumns (omitted when r=0); key register steps backward one round (inverse schedule, Rcon reversed); counter decrements.
REQ-016 ROUND -> FIN after the r=0 round; FIN registers DOUT, asserts DONE for one cycle, -> IDLE.
REQ-017 Latency: DONE is high in the cycle beginning at the 21st rising edge after the START-sampling edge; fixed, data-independent.
REQ-018 BUSY=0 in IDLE and in FIN; START in the DONE cycle is accepted (back-to-back throughput 1 block / 21 cycles).
REQ-019 START while BUSY=1 SHALL be ignored with no effect on the operation in progress.
REQ-020 DOUT SHALL change only at FIN; DONE SHALL never be high for two consecutive cycles.
REQ-021 DONE output SHALL be directly compatible as START of a following stage (chaining of instances, and encryptor DONE -> decryptor START).

Reset
REQ-022 RST low SHALL asynchronously force: FSM=IDLE, counter=0, BUSY=0, DONE=0, DOUT=0, state and key registers=0.
REQ-023 Reset mid-operation SHALL abort with no DONE pulse; first START after RST release is accepted normally.
REQ-024 START sampled in the same edge as RST release SHALL be accepted only if RST was high at that edge.

Structure
REQ-025 Shared include aes128_defs: forward S-box table, inverse S-box table, Rcon table, xtime/GF(2^8) multiply-by-{09,0B,0D,0E} functions; shared with the encryptor core.
REQ-026 One sub-module aes_inv_round: combinational InvShiftRows/InvSubBytes/AddRoundKey/optional InvMixColumns, 128-bit in/out, last-round select.
REQ-027 Key schedule forward/backward step SHALL be local logic in aes128_dsp_inv using forward S-box only.
REQ-028 No block RAM; S-boxes as combinational tables.

Verification
REQ-029 FIPS-197 C.1: KEY=000102030405060708090a0b0c0d0e0f, DIN=69c4e0d86a7b0430d8cdb78070b4c55a, START 1 cycle -> DONE at edge 21, DOUT=00112233445566778899aabbccddeeff.
REQ-030 FIPS-197 App. B: KEY=2b7e151628aed2a6abf7158809cf4f3c, DIN=3925841d02dc09fbdc118597196a0b32 -> DOUT=3243f6a8885a308d313198a2e0370734.
REQ-031 START pulsed at cycles 5 and 12 of a C.1 operation with different DIN/KEY -> single DONE at edge 21, DOUT=C.1 plaintext.
REQ-032 RST low at cycle 15 of an operation -> BUSY, DONE, DOUT all 0 immediately; no DONE afterwards; next C.1 run correct.
REQ-033 START held high continuously with C.1 then App. B inputs switched at each DONE -> DONE every 21 cycles, alternating correct plaintexts.
REQ-034 Round trip: encryptor DONE/DOUT chained into aes128_dsp_inv START/DIN, same KEY, 1000 random blocks -> DOUT equals original plaintext.
